reg_write_bank: RTL and testbench

Write side of the CPU's four-register select interface. It holds registers A, B, C and D, and presents them as parallel outputs for the 4:1 read mux. It accepts register writes through a valid/ready handshake into a small in-order write queue. The queue commits one write per clock into the selected register unless the pipeline asserts `hold`.

---
 rtl/reg_write_bank_if.sv | 16 +
 rtl/reg_write_bank.sv | 111 +++++++++++
 tb/tb_reg_write_bank.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_bank_if.sv
// Write-request handshake bundle for reg_write_bank.
//   wr_valid : source has a write request
//   wr_ready : bank can accept a request this cycle
//   wr_sel   : target register (00=B, 01=C, 10=D, 11=A)
//   wr_data  : value to write
interface reg_write_bank_if #(
   parameter int unsigned WIDTH = 8
);
   logic             wr_valid;
   logic             wr_ready;
   logic [1:0]       wr_sel;
   logic [WIDTH-1:0] wr_data;

   modport master (output wr_valid, output wr_sel, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_sel, input wr_data, output wr_ready);
endinterface

// File: rtl/reg_write_bank.sv
// Write side of the four-register bank: an in-order write queue of DEPTH
// entries that commits one write per clock into A/B/C/D unless held.
//   clk, rst_n         : clock, asynchronous active-low reset
//   wr_if (slave)      : valid/ready write request {wr_sel, wr_data}
//   hold               : stall, no commit while high
//   Aout..Dout         : registered register contents
//   wr_ack, ack_sel    : one-cycle commit pulse and the sel just committed
//   pend_cnt           : number of queued, uncommitted writes
module reg_write_bank #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   reg_write_bank_if.slave     wr_if,
   input  logic                hold,
   output logic [WIDTH-1:0]    Aout,
   output logic [WIDTH-1:0]    Bout,
   output logic [WIDTH-1:0]    Cout,
   output logic [WIDTH-1:0]    Dout,
   output logic                wr_ack,
   output logic [1:0]          ack_sel,
   output logic [1:0]          pend_cnt
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [1:0]       sel;
      logic [WIDTH-1:0] data;
   } entry_t;

   entry_t           q_mem_q [DEPTH];
   entry_t           q_mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] reg_q [4];
   logic [WIDTH-1:0] reg_d [4];
   logic             ack_q, ack_d;
   logic [1:0]       ack_sel_q, ack_sel_d;

   logic             push_c;
   logic             pop_c;
   entry_t           head_c;

   // Pointer advance with wrap at DEPTH (need not be a power of two).
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Ready depends on the occupancy flop only.
   assign wr_if.wr_ready = (cnt_q < 2'(DEPTH));
   assign push_c         = wr_if.wr_valid && wr_if.wr_ready;
   assign pop_c          = (cnt_q != 2'd0) && !hold;
   assign head_c         = q_mem_q[rd_ptr_q];

   // Queue push/pop and register commit; the pushed entry is never the popped one.
   always_comb begin
      q_mem_d   = q_mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      reg_d     = reg_q;
      ack_d     = 1'b0;
      ack_sel_d = ack_sel_q;

      if (pop_c) begin
         rd_ptr_d             = ptr_inc(rd_ptr_q);
         reg_d[head_c.sel]    = head_c.data;
         ack_d                = 1'b1;
         ack_sel_d            = head_c.sel;
      end

      if (push_c) begin
         q_mem_d[wr_ptr_q] = '{sel: wr_if.wr_sel, data: wr_if.wr_data};
         wr_ptr_d          = ptr_inc(wr_ptr_q);
      end

      cnt_d = cnt_q + 2'(push_c) - 2'(pop_c);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) q_mem_q[i] <= '0;
         for (int i = 0; i < 4; i++) reg_q[i] <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         ack_q     <= 1'b0;
         ack_sel_q <= '0;
      end else begin
         q_mem_q   <= q_mem_d;
         reg_q     <= reg_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         ack_sel_q <= ack_sel_d;
      end
   end

   // Register index follows the sel encoding: 00=B, 01=C, 10=D, 11=A.
   assign Bout     = reg_q[0];
   assign Cout     = reg_q[1];
   assign Dout     = reg_q[2];
   assign Aout     = reg_q[3];
   assign wr_ack   = ack_q;
   assign ack_sel  = ack_sel_q;
   assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_reg_write_bank.sv
// Self-checking bench for reg_write_bank: directed scenarios plus random
// traffic, compared every cycle against a queue-based behavioural model.
module tb_reg_write_bank;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 2;

   logic             clk;
   logic             rst_n;
   logic             hold;
   logic [WIDTH-1:0] Aout, Bout, Cout, Dout;
   logic             wr_ack;
   logic [1:0]       ack_sel;
   logic [1:0]       pend_cnt;

   reg_write_bank_if #(.WIDTH(WIDTH)) wif ();

   reg_write_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_if    (wif.slave),
      .hold     (hold),
      .Aout     (Aout),
      .Bout     (Bout),
      .Cout     (Cout),
      .Dout     (Dout),
      .wr_ack   (wr_ack),
      .ack_sel  (ack_sel),
      .pend_cnt (pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: a FIFO of pending writes and a named register file.
   typedef struct {
      logic [1:0] sel;
      logic [7:0] data;
   } ent_t;

   ent_t       mq[$];
   logic [7:0] m_a, m_b, m_c, m_d;
   bit         m_ack;
   logic [1:0] m_ack_sel;
   bit         last_push;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_a = '0; m_b = '0; m_c = '0; m_d = '0;
      m_ack = 1'b0;
      m_ack_sel = 2'b00;
      last_push = 1'b0;
   endtask

   // One rising edge of the model, using the inputs that were stable before it.
   task automatic model_step();
      ent_t h;
      bit   push;
      if (!rst_n) begin
         model_reset();
         return;
      end
      push = wif.wr_valid && (mq.size() < DEPTH);
      m_ack = 1'b0;
      if (mq.size() > 0 && !hold) begin
         h = mq.pop_front();
         case (h.sel)
            2'b11:   m_a = h.data;
            2'b00:   m_b = h.data;
            2'b01:   m_c = h.data;
            default: m_d = h.data;
         endcase
         m_ack = 1'b1;
         m_ack_sel = h.sel;
      end
      if (push) mq.push_back('{sel: wif.wr_sel, data: wif.wr_data});
      last_push = push;
   endtask

   // Drive at the falling edge, advance the model on the rising edge.
   task automatic cycle(input bit v, input logic [1:0] s, input logic [7:0] d, input bit h);
      wif.wr_valid = v;
      wif.wr_sel   = s;
      wif.wr_data  = d;
      hold         = h;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 8'h00, 1'b0);
   endtask

   // Compare process: every cycle, shortly after the rising edge.
   always begin
      @(posedge clk);
      #2;
      if (chk_en) begin
         chk("Aout",     32'(Aout),     32'(m_a));
         chk("Bout",     32'(Bout),     32'(m_b));
         chk("Cout",     32'(Cout),     32'(m_c));
         chk("Dout",     32'(Dout),     32'(m_d));
         chk("wr_ack",   32'(wr_ack),   32'(m_ack));
         chk("ack_sel",  32'(ack_sel),  32'(m_ack_sel));
         chk("pend_cnt", 32'(pend_cnt), 32'(mq.size()));
         chk("wr_ready", 32'(wif.wr_ready), 32'(mq.size() < DEPTH));
      end
   end

   initial begin
      bit         pv;
      logic [1:0] ps;
      logic [7:0] pd;

      rst_n        = 1'b0;
      hold         = 1'b0;
      wif.wr_valid = 1'b0;
      wif.wr_sel   = 2'b00;
      wif.wr_data  = 8'h00;
      model_reset();
      chk_en = 1'b1;
      @(negedge clk);
      idle(2);
      chk("rst_ready", 32'(wif.wr_ready), 32'd1);
      chk("rst_pend",  32'(pend_cnt), 32'd0);
      rst_n = 1'b1;

      // Single write to A.
      cycle(1'b1, 2'b11, 8'h5A, 1'b0);
      chk("single_pend", 32'(pend_cnt), 32'd1);
      cycle(1'b0, 2'b00, 8'h00, 1'b0);
      chk("single_A",   32'(Aout),    32'h5A);
      chk("single_ack", 32'(wr_ack),  32'd1);
      chk("single_sel", 32'(ack_sel), 32'd3);
      chk("single_B",   32'(Bout),    32'd0);
      idle(1);
      chk("single_ack_low", 32'(wr_ack), 32'd0);

      // Back-to-back streaming.
      cycle(1'b1, 2'b00, 8'h11, 1'b0);
      cycle(1'b1, 2'b01, 8'h22, 1'b0);
      cycle(1'b1, 2'b10, 8'h33, 1'b0);
      cycle(1'b1, 2'b11, 8'h44, 1'b0);
      idle(1);
      chk("stream_B", 32'(Bout), 32'h11);
      chk("stream_C", 32'(Cout), 32'h22);
      chk("stream_D", 32'(Dout), 32'h33);
      chk("stream_A", 32'(Aout), 32'h44);

      // Fill under hold, third request waits for ready.
      cycle(1'b1, 2'b00, 8'h01, 1'b1);
      cycle(1'b1, 2'b00, 8'h02, 1'b1);
      chk("full_pend",  32'(pend_cnt), 32'd2);
      chk("full_ready", 32'(wif.wr_ready), 32'd0);
      cycle(1'b1, 2'b01, 8'h77, 1'b1);
      cycle(1'b1, 2'b01, 8'h77, 1'b1);
      chk("hold_ack", 32'(wr_ack), 32'd0);
      cycle(1'b1, 2'b01, 8'h77, 1'b0);
      chk("release_B1", 32'(Bout), 32'h01);
      for (int i = 0; i < 6 && !last_push; i++) cycle(1'b1, 2'b01, 8'h77, 1'b0);
      chk("release_B2", 32'(Bout), 32'h02);
      idle(3);
      chk("third_C", 32'(Cout), 32'h77);

      // Simultaneous push and pop.
      cycle(1'b1, 2'b10, 8'hAA, 1'b0);
      cycle(1'b1, 2'b10, 8'hBB, 1'b0);
      chk("pp_pend", 32'(pend_cnt), 32'd1);
      chk("pp_D1",   32'(Dout), 32'hAA);
      idle(1);
      chk("pp_D2",   32'(Dout), 32'hBB);

      // Reset with two writes pending.
      cycle(1'b1, 2'b00, 8'hE1, 1'b1);
      cycle(1'b1, 2'b01, 8'hE2, 1'b1);
      rst_n = 1'b0;
      wif.wr_valid = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_pend",  32'(pend_cnt), 32'd0);
      chk("mid_rst_ready", 32'(wif.wr_ready), 32'd1);
      chk("mid_rst_B",     32'(Bout), 32'd0);
      chk("mid_rst_ack",   32'(wr_ack), 32'd0);
      @(negedge clk);
      idle(2);
      rst_n = 1'b1;
      idle(4);
      chk("no_stale_B", 32'(Bout), 32'd0);
      chk("no_stale_C", 32'(Cout), 32'd0);

      // Random traffic with random hold; source holds a request until taken.
      pv = 1'b0;
      ps = 2'b00;
      pd = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if (!pv && $urandom_range(0, 3) != 0) begin
            pv = 1'b1;
            ps = 2'($urandom_range(0, 3));
            pd = 8'($urandom);
         end
         cycle(pv, ps, pd, $urandom_range(0, 3) == 0);
         if (last_push) pv = 1'b0;
      end
      idle(4);
      chk("drain_pend", 32'(pend_cnt), 32'd0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
